// File: rtl/alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_unit : execute-stage ALU with funct decode and iterative RV32M      |
// |                multiply/divide engine behind valid/ready handshakes.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_seq_unit #(
   parameter int XLEN    = 32,
   parameter bit MEXT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic            funct7b0,
   input  logic            opb5,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int C_SHW  = $clog2(XLEN);
   localparam int C_CNTW = $clog2(XLEN);
   localparam logic [C_CNTW-1:0] C_LAST = C_CNTW'(XLEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [C_CNTW-1:0] r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_mcand;
   logic [2:0]        r_f3;
   logic              r_neg;
   logic [XLEN-1:0]   r_result;
   logic              r_zero;

   logic [C_SHW-1:0]  w_shamt;
   logic [XLEN-1:0]   w_sra;
   logic              w_lt;
   logic              w_ltu;
   logic [XLEN-1:0]   w_base;
   logic              w_is_m;
   logic              w_sgn_a;
   logic              w_sgn_b;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_neg;
   logic [XLEN:0]     w_hi_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN-1:0]   w_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_acc_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_dsel;
   logic [XLEN-1:0]   w_m_res;

   // Single-cycle base operations
   always_comb begin
      w_shamt = b[C_SHW-1:0];
      w_sra   = $signed(a) >>> w_shamt;
      w_lt    = $signed(a) < $signed(b);
      w_ltu   = a < b;
      w_base  = a + b;
      case (ALUOp)
         2'b00: w_base = a + b;
         2'b01: w_base = a - b;
         2'b11: w_base = {{(XLEN-1){1'b0}}, w_lt};
         default: begin
            case (funct3)
               3'b000: w_base = (funct7b5 & opb5) ? (a - b) : (a + b);
               3'b001: w_base = a << w_shamt;
               3'b010: w_base = {{(XLEN-1){1'b0}}, w_lt};
               3'b011: w_base = {{(XLEN-1){1'b0}}, w_ltu};
               3'b100: w_base = a ^ b;
               3'b101: w_base = funct7b5 ? w_sra : (a >> w_shamt);
               3'b110: w_base = a | b;
               default: w_base = a & b;
            endcase
         end
      endcase
   end

   // M-op setup: the engine works on magnitudes, r_neg records the final sign fix
   always_comb begin
      w_is_m  = MEXT_EN && (ALUOp == 2'b10) && opb5 && funct7b0;
      w_sgn_a = a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                             (funct3 == 3'b100) | (funct3 == 3'b110));
      w_sgn_b = b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                             (funct3 == 3'b110));
      w_mag_a = w_sgn_a ? (~a + 1'b1) : a;
      w_mag_b = w_sgn_b ? (~b + 1'b1) : b;
      if (funct3[2]) begin
         // A zero divisor keeps the all-ones quotient unsigned-looking
         w_neg = funct3[1] ? w_sgn_a : ((w_sgn_a ^ w_sgn_b) & (b != '0));
      end else begin
         w_neg = w_sgn_a ^ w_sgn_b;
      end
   end

   // One iteration step: shift-add multiply or restoring divide on {hi, lo}
   always_comb begin
      w_hi_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand};
      w_shift  = r_acc[2*XLEN-1:XLEN-1];
      w_diff   = w_shift[XLEN-1:0] - r_mcand;
      w_ge     = w_shift >= {1'b0, r_mcand};
      if (r_f3[2]) begin
         w_acc_nxt = {(w_ge ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
      end else if (r_acc[0]) begin
         w_acc_nxt = {w_hi_sum, r_acc[XLEN-1:1]};
      end else begin
         w_acc_nxt = {1'b0, r_acc[2*XLEN-1:1]};
      end
   end

   always_comb begin
      w_prod  = r_neg ? (~r_acc + 1'b1) : r_acc;
      w_dsel  = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
      if (r_f3[2]) begin
         w_m_res = r_neg ? (~w_dsel + 1'b1) : w_dsel;
      end else if (r_f3 == 3'b000) begin
         w_m_res = w_prod[XLEN-1:0];
      end else begin
         w_m_res = w_prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_f3     <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_m) begin
                     r_f3    <= funct3;
                     r_neg   <= w_neg;
                     r_cnt   <= '0;
                     r_mcand <= funct3[2] ? w_mag_b : w_mag_a;
                     r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                     r_state <= S_ITER;
                  end else begin
                     r_result <= w_base;
                     r_zero   <= (w_base == '0);
                     r_state  <= S_DONE;
                  end
               end
            end
            S_ITER: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result <= w_m_res;
               r_zero   <= (w_m_res == '0);
               r_state  <= S_DONE;
            end
            default: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_ITER) || (r_state == S_FIX);
   assign result    = r_result;
   assign zero      = r_zero;

endmodule
`default_nettype wire
